// File: rtl/gates_array.sv
// gates_array: parameterised two-operand bitwise logic unit.
// Computes AND, OR, NAND, NOR, XOR and XNOR of a and b in parallel.
// All six results sit behind one valid-qualified register stage, so the
// outputs come only from flops and have no combinational path from a/b.
module gates_array #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         out_valid,
    output logic [n-1:0] y_and,
    output logic [n-1:0] y_or,
    output logic [n-1:0] y_nand,
    output logic [n-1:0] y_nor,
    output logic [n-1:0] y_xor,
    output logic [n-1:0] y_xnor
);

    logic [n-1:0] and_d,  and_q;
    logic [n-1:0] or_d,   or_q;
    logic [n-1:0] nand_d, nand_q;
    logic [n-1:0] nor_d,  nor_q;
    logic [n-1:0] xor_d,  xor_q;
    logic [n-1:0] xnor_d, xnor_q;
    logic         valid_d, valid_q;

    // Evaluate all six functions; bit i depends only on a[i] and b[i]
    always_comb begin
        and_d   = a & b;
        or_d    = a | b;
        nand_d  = ~(a & b);
        nor_d   = ~(a | b);
        xor_d   = a ^ b;
        xnor_d  = ~(a ^ b);
        valid_d = in_valid;
    end

    // Valid flag tracks in_valid every edge; reset clears it immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Result registers load on a valid cycle and hold otherwise; reset zeroes all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            and_q  <= '0;
            or_q   <= '0;
            nand_q <= '0;
            nor_q  <= '0;
            xor_q  <= '0;
            xnor_q <= '0;
        end else if (in_valid) begin
            and_q  <= and_d;
            or_q   <= or_d;
            nand_q <= nand_d;
            nor_q  <= nor_d;
            xor_q  <= xor_d;
            xnor_q <= xnor_d;
        end
    end

    assign out_valid = valid_q;
    assign y_and     = and_q;
    assign y_or      = or_q;
    assign y_nand    = nand_q;
    assign y_nor     = nor_q;
    assign y_xor     = xor_q;
    assign y_xnor    = xnor_q;

endmodule

// File: tb/tb_gates_array.sv
// tb_gates_array: drives three gates_array instances (n=4, n=1, n=8) and
// compares them against a per-bit truth-count reference model.
module tb_gates_array;

    logic clk;
    logic rst;

    // Per-instance stimulus: index 0 -> n=4, 1 -> n=1, 2 -> n=8
    logic [7:0] ain [3];
    logic [7:0] bin [3];
    logic       vin [3];
    int         wid [3];

    // Observed outputs, zero-extended to 8 bits, order: and,or,nand,nor,xor,xnor
    logic [5:0][7:0] obs [3];
    logic            ovld [3];

    // Reference model state
    logic [5:0][7:0] exp_y [3];
    logic            exp_v [3];

    int checks;
    int failures;

    logic       v4, v1, v8;
    logic [3:0] and4, or4, nand4, nor4, xor4, xnor4;
    logic [0:0] and1, or1, nand1, nor1, xor1, xnor1;
    logic [7:0] and8, or8, nand8, nor8, xor8, xnor8;
    logic [3:0] a4, b4;
    logic [0:0] a1, b1;
    logic [7:0] a8, b8;
    logic       iv4, iv1, iv8;

    assign a4 = ain[0][3:0];
    assign b4 = bin[0][3:0];
    assign a1 = ain[1][0:0];
    assign b1 = bin[1][0:0];
    assign a8 = ain[2];
    assign b8 = bin[2];
    assign iv4 = vin[0];
    assign iv1 = vin[1];
    assign iv8 = vin[2];

    gates_array #(.n(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .out_valid(v4),
        .y_and(and4), .y_or(or4), .y_nand(nand4), .y_nor(nor4), .y_xor(xor4), .y_xnor(xnor4)
    );
    gates_array #(.n(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .out_valid(v1),
        .y_and(and1), .y_or(or1), .y_nand(nand1), .y_nor(nor1), .y_xor(xor1), .y_xnor(xnor1)
    );
    gates_array #(.n(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .out_valid(v8),
        .y_and(and8), .y_or(or8), .y_nand(nand8), .y_nor(nor8), .y_xor(xor8), .y_xnor(xnor8)
    );

    assign obs[0] = {8'(xnor4), 8'(xor4), 8'(nor4), 8'(nand4), 8'(or4), 8'(and4)};
    assign obs[1] = {8'(xnor1), 8'(xor1), 8'(nor1), 8'(nand1), 8'(or1), 8'(and1)};
    assign obs[2] = {xnor8, xor8, nor8, nand8, or8, and8};
    assign ovld[0] = v4;
    assign ovld[1] = v1;
    assign ovld[2] = v8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count of ones in (a[i], b[i]) decides each function's bit
    function automatic logic [7:0] ref_fn(input int op, input logic [7:0] x,
                                          input logic [7:0] y, input int w);
        logic [7:0] r;
        int c;
        r = '0;
        for (int i = 0; i < w; i++) begin
            c = int'(x[i]) + int'(y[i]);
            case (op)
                0:       r[i] = (c == 2);
                1:       r[i] = (c >= 1);
                2:       r[i] = (c != 2);
                3:       r[i] = (c == 0);
                4:       r[i] = (c == 1);
                default: r[i] = (c != 1);
            endcase
        end
        return r;
    endfunction

    function automatic logic [7:0] mask_of(input int w);
        return 8'((1 << w) - 1);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            exp_v[k] = 1'b0;
            exp_y[k] = '0;
        end
    endtask

    // Advance one rising edge, update the model, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp_v[k] = vin[k];
                if (vin[k]) begin
                    for (int op = 0; op < 6; op++)
                        exp_y[k][op] = ref_fn(op, ain[k], bin[k], wid[k]);
                end
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] m;
        for (int k = 0; k < 3; k++) begin
            checks++;
            assert (ovld[k] === exp_v[k]) else begin
                failures++;
                $error("FAIL %s dut%0d out_valid observed=%b expected=%b", tag, k, ovld[k], exp_v[k]);
            end
            for (int op = 0; op < 6; op++) begin
                checks++;
                assert (obs[k][op] === exp_y[k][op]) else begin
                    failures++;
                    $error("FAIL %s dut%0d op%0d observed=%h expected=%h", tag, k, op, obs[k][op], exp_y[k][op]);
                end
            end
            if (ovld[k] === 1'b1) begin
                m = mask_of(wid[k]);
                checks++;
                assert ((obs[k][2] === (~obs[k][0] & m)) && (obs[k][3] === (~obs[k][1] & m)) &&
                        (obs[k][5] === (~obs[k][4] & m)) && (obs[k][4] === (obs[k][1] & obs[k][2])))
                else begin
                    failures++;
                    $error("FAIL %s dut%0d invariants observed=%h expected consistent complements", tag, k, obs[k]);
                end
            end
        end
    endtask

    // Directed literal check on the n=4 instance
    task automatic lit4(input string tag, input logic vld, input logic [3:0] e_and, input logic [3:0] e_or,
                        input logic [3:0] e_nand, input logic [3:0] e_nor,
                        input logic [3:0] e_xor, input logic [3:0] e_xnor);
        logic [23:0] got;
        logic [23:0] want;
        got  = {and4, or4, nand4, nor4, xor4, xnor4};
        want = {e_and, e_or, e_nand, e_nor, e_xor, e_xnor};
        checks++;
        assert ((got === want) && (v4 === vld)) else begin
            failures++;
            $error("FAIL %s observed=%h vld=%b expected=%h vld=%b", tag, got, v4, want, vld);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        wid[0] = 4; wid[1] = 1; wid[2] = 8;
        for (int k = 0; k < 3; k++) begin
            ain[k] = '0; bin[k] = '0; vin[k] = 1'b0;
        end
        model_clear();
        rst = 1'b1;

        // Reset held across edges
        step();
        step();
        check_all("reset");
        lit4("reset_lit", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        step();
        check_all("post_reset_idle");

        // First capture
        ain[0] = 8'b1010; bin[0] = 8'b1100; vin[0] = 1'b1;
        step();
        check_all("first_capture");
        lit4("first_lit", 1'b1, 4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001);

        // Back-to-back
        ain[0] = 8'b0001; bin[0] = 8'b0011;
        step();
        lit4("b2b_1", 1'b1, 4'b0001, 4'b0011, 4'b1110, 4'b1100, 4'b0010, 4'b1101);
        ain[0] = 8'b1111; bin[0] = 8'b0000;
        step();
        lit4("b2b_2", 1'b1, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
        check_all("b2b");

        // Equal operands, then hold with changing inputs
        ain[0] = 8'b1010; bin[0] = 8'b1010;
        step();
        lit4("equal", 1'b1, 4'b1010, 4'b1010, 4'b0101, 4'b0101, 4'b0000, 4'b1111);
        vin[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ain[0] = 8'($urandom_range(0, 15));
            bin[0] = 8'($urandom_range(0, 15));
            step();
            lit4("hold", 1'b0, 4'b1010, 4'b1010, 4'b0101, 4'b0101, 4'b0000, 4'b1111);
        end
        check_all("hold");

        // Reset mid-stream between edges
        ain[0] = 8'b1010; bin[0] = 8'b1100; vin[0] = 1'b1;
        step();
        lit4("pre_mid_reset", 1'b1, 4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_all("async_reset");
        lit4("async_reset_lit", 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        ain[0] = 8'b0110; bin[0] = 8'b0011; vin[0] = 1'b1;
        step();
        check_all("valid_during_reset");
        #2;
        rst = 1'b0;
        vin[0] = 1'b0;
        step();
        check_all("after_reset_release");

        // n=1 exhaustive
        for (int x = 0; x < 2; x++) begin
            for (int y = 0; y < 2; y++) begin
                ain[1] = 8'(x); bin[1] = 8'(y); vin[1] = 1'b1;
                step();
                check_all("n1_exhaustive");
            end
        end

        // Random traffic on all widths, with random valid
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 3; k++) begin
                ain[k] = 8'($urandom) & mask_of(wid[k]);
                bin[k] = 8'($urandom) & mask_of(wid[k]);
                vin[k] = ($urandom_range(0, 3) != 0);
            end
            step();
            check_all("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
